// File: rtl/pmem_resp_pkg.sv
// pmem_resp_pkg: shared constants and enums for the pmem line responder.
//   PMEM_LINE_W    - default cache-line width in bits
//   PMEM_OFFSET_W  - byte-offset field width within a line
//   pmem_resp_state_t - responder FSM states
//   pmem_op_t      - latched operation kind
package pmem_resp_pkg;

    localparam int PMEM_LINE_W   = 256;
    localparam int PMEM_OFFSET_W = $clog2(PMEM_LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } pmem_resp_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } pmem_op_t;

endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: single-port DEPTH_LINES x LINE_W line storage.
// Synchronous read and synchronous write; contents are never reset.
// Ports:
//   clk   - clock
//   addr  - line index for both read and write
//   we    - write enable
//   wdata - line write data
//   rdata - registered read data, mem[addr] as sampled at the previous edge
module pmem_line_array
    import pmem_resp_pkg::*;
#(
    parameter int LINE_W      = PMEM_LINE_W,
    parameter int DEPTH_LINES = 256,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  addr,
    input  logic              we,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency on-chip backing store for the mp3
// pmem_* cache-line port. One read or write at a time; pmem_resp pulses
// LATENCY+1 cycles after the request is seen in IDLE.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous reset, active-low
//   pmem_read  - line read request, held until pmem_resp
//   pmem_write - line write request, held until pmem_resp
//   pmem_addr  - byte address of the line (offset bits ignored, index aliases)
//   pmem_wdata - line write data
//   pmem_resp  - one-cycle completion pulse
//   pmem_rdata - read data, updated only on a read response
//   pmem_error - sticky protocol-violation flag
// Optional feature macro: PMEM_RESP_PROTO_CHECK_EN enables the protocol
// checker driving pmem_error; otherwise pmem_error is tied low.
module pmem_line_responder
    import pmem_resp_pkg::*;
#(
    parameter int LINE_W      = PMEM_LINE_W,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_addr,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_error
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    pmem_resp_state_t  state;
    pmem_op_t          op;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] wdata_q;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  arr_addr;
    logic              arr_we;
    logic [LINE_W-1:0] arr_rdata;
    logic              unused_addr_bits;

    always_comb begin
        req_idx = pmem_addr[OFF_W +: IDX_W];
    end

    // Offset and upper address bits carry no meaning for line selection.
    assign unused_addr_bits = ^pmem_addr;

    // The array is addressed straight from the port while idle so the line
    // is already being read during the first BUSY cycle; this keeps read
    // data valid at the last BUSY cycle even when LATENCY is 1.
    always_comb begin
        arr_addr = (state == IDLE) ? req_idx : idx;
    end

    // Gated by rst so a reset landing in RESP aborts the commit.
    always_comb begin
        arr_we = rst && (state == RESP) && (op == OP_WRITE);
    end

    pmem_line_array #(
        .LINE_W      (LINE_W),
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk   (clk),
        .addr  (arr_addr),
        .we    (arr_we),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            op         <= OP_READ;
            idx        <= '0;
            cnt        <= '0;
            wdata_q    <= '0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        op      <= pmem_read ? OP_READ : OP_WRITE;
                        idx     <= req_idx;
                        wdata_q <= pmem_wdata;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                        if (op == OP_READ) begin
                            pmem_rdata <= arr_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PMEM_RESP_PROTO_CHECK_EN
    logic [31:0] addr_q;
    logic        rd_q;
    logic        wr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pmem_error <= 1'b0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            if (state == IDLE && (pmem_read || pmem_write)) begin
                addr_q <= pmem_addr;
                rd_q   <= pmem_read;
                wr_q   <= pmem_write;
                if (pmem_read && pmem_write) begin
                    pmem_error <= 1'b1;
                end
            end
            if (state == BUSY) begin
                if ((rd_q && !pmem_read) || (wr_q && !pmem_write) ||
                    (pmem_addr != addr_q) ||
                    (op == OP_WRITE && pmem_wdata != wdata_q)) begin
                    pmem_error <= 1'b1;
                end
            end
        end
    end
`else
    assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

    localparam int LW      = 256;
    localparam int LAT     = 8;
    localparam int RESP_AT = LAT + 1;

`ifdef PMEM_RESP_PROTO_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pmem_read = 1'b0;
    logic          pmem_write = 1'b0;
    logic [31:0]   pmem_addr = '0;
    logic [LW-1:0] pmem_wdata = '0;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_line_responder #(
        .LINE_W      (LW),
        .DEPTH_LINES (256),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_resp  (pmem_resp),
        .pmem_rdata (pmem_rdata),
        .pmem_error (pmem_error)
    );

    typedef struct {
        logic [LW-1:0] rdata;
        int            id;
    } exp_t;

    exp_t          sb[$];
    logic [LW-1:0] last_rd = '0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every response pops one expectation; write responses
    // expect pmem_rdata unchanged from the previous read.
    always @(negedge clk) begin
        exp_t e;
        if (pmem_resp === 1'b1) begin
            if (sb.size() == 0) begin
                chk_int("unexpected_resp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rdata_txn%0d", e.id), pmem_rdata, e.rdata);
            end
        end
    end

    // Drives one request starting in the cycle after the call, holds it until
    // pmem_resp is seen, then drops it. Returns latency and response cycle.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [LW-1:0] wd, input logic [LW-1:0] exp_rd,
                       input int id, output int lat, output int rcyc);
        @(posedge clk);
        @(negedge clk);
        pmem_read  = rd;
        pmem_write = wr;
        pmem_addr  = addr;
        pmem_wdata = wd;
        if (rd) last_rd = exp_rd;
        sb.push_back('{last_rd, id});
        lat  = -1;
        rcyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (pmem_resp === 1'b1) begin
                lat  = k;
                rcyc = cyc;
                break;
            end
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        chk_int($sformatf("latency_txn%0d", id), lat, RESP_AT);
    endtask

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] exp;
        logic          gap;
    } vec_t;

    vec_t vt[11];

    initial begin
        int lat, rcyc, prev_rcyc, r1, r2;
        logic [LW-1:0] d_beef, a0, a1, a2, d3, old5, c3, new5;

        d_beef = {8{32'hDEAD_BEEF}};
        a0     = {8{32'hA0A0_0000}};
        a1     = {8{32'hA1A1_1111}};
        a2     = {8{32'hA2A2_2222}};
        d3     = {8{32'hD3D3_3333}};
        old5   = {8{32'h0505_5555}};
        c3     = {8{32'hCCCC_3333}};
        new5   = {8{32'hBAD0_5555}};

        // {wr, addr, wdata, expected read data, check 10-cycle spacing}
        vt[0]  = '{1'b1, 32'h0000_0040, d_beef, '0,     1'b0};
        vt[1]  = '{1'b0, 32'h0000_0040, '0,     d_beef, 1'b0};
        vt[2]  = '{1'b0, 32'h0000_205F, '0,     d_beef, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_0000, a0,     '0,     1'b0};
        vt[4]  = '{1'b1, 32'h0000_0020, a1,     '0,     1'b1};
        vt[5]  = '{1'b1, 32'h0000_0040, a2,     '0,     1'b1};
        vt[6]  = '{1'b0, 32'h0000_0040, '0,     a2,     1'b0};
        vt[7]  = '{1'b0, 32'hFFFF_E000, '0,     a0,     1'b0};
        vt[8]  = '{1'b0, 32'h0000_0020, '0,     a1,     1'b0};
        vt[9]  = '{1'b1, 32'h0000_0060, d3,     '0,     1'b0};
        vt[10] = '{1'b1, 32'h0000_00A0, old5,   '0,     1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", LW'(pmem_resp), '0);
        chk("reset_rdata", pmem_rdata, '0);
        chk("reset_error", LW'(pmem_error), '0);
        rst = 1'b1;

        prev_rcyc = 0;
        for (int i = 0; i < 11; i++) begin
            txn(!vt[i].wr, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp, i, lat, rcyc);
            if (vt[i].gap) chk_int($sformatf("resp_gap_txn%0d", i), rcyc - prev_rcyc, RESP_AT + 1);
            prev_rcyc = rcyc;
        end

        // Read and write together on line 3: read wins, write never commits.
        txn(1'b1, 1'b1, 32'h0000_0060, c3, d3, 20, lat, rcyc);
        chk("both_error", LW'(pmem_error), LW'(ERR_EXP));
        txn(1'b1, 1'b0, 32'h0000_0060, '0, d3, 21, lat, rcyc);
        chk("both_error_sticky", LW'(pmem_error), LW'(ERR_EXP));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("error_cleared", LW'(pmem_error), '0);
        last_rd = '0;
        rst = 1'b1;

        // Write aborted by reset in cycle 4: line 5 keeps its old contents.
        txn(1'b0, 1'b1, 32'h0000_0020, a1, '0, 22, lat, rcyc);
        @(posedge clk);
        @(negedge clk);
        pmem_write = 1'b1;
        pmem_addr  = 32'h0000_00A0;
        pmem_wdata = new5;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_resp", LW'(pmem_resp), '0);
        chk("abort_rdata", pmem_rdata, '0);
        chk("abort_error", LW'(pmem_error), '0);
        last_rd    = '0;
        pmem_write = 1'b0;
        rst        = 1'b1;
        repeat (12) @(posedge clk);
        txn(1'b1, 1'b0, 32'h0000_00A0, '0, old5, 23, lat, rcyc);

        // Read held one cycle past pmem_resp is accepted again in the next
        // IDLE cycle and answered LATENCY+1 cycles after that acceptance.
        @(posedge clk);
        @(negedge clk);
        pmem_read = 1'b1;
        pmem_addr = 32'h0000_0000;
        last_rd   = a0;
        sb.push_back('{a0, 24});
        sb.push_back('{a0, 25});
        r1 = -1;
        r2 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (pmem_resp === 1'b1) begin
                if (r1 < 0) r1 = cyc;
                else begin
                    r2 = cyc;
                    break;
                end
            end
            if (r1 >= 0 && cyc == r1 + 2) pmem_read = 1'b0;
        end
        pmem_read = 1'b0;
        chk_int("hold_second_resp_gap", r2 - r1, RESP_AT + 1);

        repeat (3) @(negedge clk);
        chk_int("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
